// File: rtl/kb_frame_rx.sv
// kb_frame_rx -- PS/2 frame receiver for the keyboard path.
// Samples the PS/2 data line on each upstream edge pulse and assembles the
// 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
// A good frame updates o_dat and pulses o_valid. A frame with bad parity,
// a bad stop bit, or a stall mid-frame pulses o_err instead.
// Ports:
//   clk        system clock
//   i_sclr_n   synchronous active-low reset
//   i_edge_en  one-cycle pulse at each PS/2 clock falling edge (sample point)
//   i_ps2_dat  raw PS/2 data line (asynchronous)
//   o_dat      last correctly received scancode
//   o_valid    one-cycle strobe: o_dat updated
//   o_err      one-cycle strobe: frame rejected
//   o_busy     frame in progress
module kb_frame_rx #(
  parameter int TIMEOUT_CYCLES   = 100000,
  parameter int TIMEOUT_BIT_SIZE = 17
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_edge_en,
  input  logic       i_ps2_dat,
  output logic [7:0] o_dat,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [TIMEOUT_BIT_SIZE-1:0] TO_LAST =
    TIMEOUT_BIT_SIZE'(TIMEOUT_CYCLES - 1);

  state_t                      state, state_nxt;
  logic [1:0]                  sync;
  logic                        dat_s;
  logic [7:0]                  shreg, shreg_nxt;
  logic [2:0]                  bit_cnt, bit_cnt_nxt;
  logic                        par, par_nxt;
  logic [TIMEOUT_BIT_SIZE-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]                  dat_nxt;
  logic                        valid_nxt, err_nxt;
  logic                        timeout;

  assign dat_s  = sync[1];
  assign o_busy = (state != IDLE);

  // Terminal count only fires in a cycle without an edge: an edge arriving
  // on the terminal cycle is accepted as a bit instead.
  assign timeout = (state != IDLE) && !i_edge_en && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par;
    dat_nxt     = o_dat;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;

    if (state == IDLE || i_edge_en) to_cnt_nxt = '0;
    else                            to_cnt_nxt = to_cnt + 1'b1;

    if (timeout) begin
      state_nxt  = IDLE;
      err_nxt    = 1'b1;
      to_cnt_nxt = '0;
    end else if (i_edge_en) begin
      case (state)
        IDLE: begin
          // A high line in IDLE is not a start bit; ignore it silently.
          if (!dat_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          shreg_nxt   = {dat_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = dat_s;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (dat_s && ((^shreg) ^ par)) begin
            dat_nxt   = shreg;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state   <= IDLE;
      sync    <= 2'b11;
      shreg   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
      o_dat   <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      sync    <= {sync[0], i_ps2_dat};
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      par     <= par_nxt;
      to_cnt  <= to_cnt_nxt;
      o_dat   <= dat_nxt;
      o_valid <= valid_nxt;
      o_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_kb_frame_rx.sv
// Bench for kb_frame_rx: table of whole frames plus hand-written sequences
// for timeout, idle noise, mid-frame reset and the terminal-count race.
module tb_kb_frame_rx;

  logic       clk = 1'b0;
  logic       i_sclr_n, i_edge_en, i_ps2_dat;
  logic [7:0] o_dat;
  logic       o_valid, o_err, o_busy;

  always #5 clk = ~clk;

  kb_frame_rx #(.TIMEOUT_CYCLES(64), .TIMEOUT_BIT_SIZE(7)) dut (
    .clk(clk), .i_sclr_n(i_sclr_n), .i_edge_en(i_edge_en),
    .i_ps2_dat(i_ps2_dat), .o_dat(o_dat), .o_valid(o_valid),
    .o_err(o_err), .o_busy(o_busy)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] dat;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       exp_err;
    logic [7:0] exp_dat;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (o_valid === 1'b1 || o_err === 1'b1) begin
      chk("strobe_exclusive", 32'(o_valid & o_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({o_valid, o_err}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_err", 32'(o_err), 32'(e.is_err));
        chk("strobe_valid", 32'(o_valid), 32'(!e.is_err));
        chk("o_dat", 32'(o_dat), 32'(e.dat));
      end
    end
  end

  // Called just after a posedge; the edge pulse is sampled exactly gap
  // cycles later, with data set up well ahead of the synchronizer.
  task automatic send_bit(input logic b, input int gap);
    i_ps2_dat = b;
    repeat (gap - 1) @(posedge clk);
    #1 i_edge_en = 1'b1;
    @(posedge clk);
    #1 i_edge_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int long_pos);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], (i == long_pos) ? 64 : 32);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b0, 8'hF0};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A};
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b1, 8'h5A};  // bad parity
    vecs[4] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h5A};  // bad stop

    i_sclr_n  = 1'b0;
    i_edge_en = 1'b0;
    i_ps2_dat = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_o_dat", 32'(o_dat), 32'h00);
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_err", 32'(o_err), 32'd0);
    chk("reset_o_busy", 32'(o_busy), 32'd0);
    realign();
    i_sclr_n = 1'b1;
    realign();

    // Table: back-to-back frames, edges 32 clk apart throughout.
    for (int v = 0; v < 5; v++) begin
      sb.push_back('{vecs[v].exp_err, vecs[v].exp_dat});
      send_frame(vecs[v].d, vecs[v].p, vecs[v].s, -1);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_after_table", 32'(o_busy), 32'd0);
    realign();

    // Stall after start + 5 data bits: error exactly 64 clk after last edge.
    sb.push_back('{1'b1, 8'h5A});
    send_bit(1'b0, 32);
    send_bit(1'b1, 32);
    send_bit(1'b0, 32);
    send_bit(1'b1, 32);
    send_bit(1'b1, 32);
    send_bit(1'b0, 32);
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("timeout_err_early", 32'(o_err), 32'd0);
    chk("timeout_busy_before", 32'(o_busy), 32'd1);
    @(negedge clk);
    chk("timeout_err", 32'(o_err), 32'd1);
    chk("timeout_busy_after", 32'(o_busy), 32'd0);
    realign();
    sb.push_back('{1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 1'b1, -1);

    // High line in IDLE is ignored.
    send_bit(1'b1, 32);
    @(negedge clk);
    chk("idle_noise_busy", 32'(o_busy), 32'd0);
    realign();

    // Reset mid-frame after 4 data bits: everything clears, no error.
    send_bit(1'b0, 32);
    send_bit(1'b1, 32);
    send_bit(1'b1, 32);
    send_bit(1'b0, 32);
    send_bit(1'b1, 32);
    @(negedge clk);
    chk("midframe_busy", 32'(o_busy), 32'd1);
    i_sclr_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_o_dat", 32'(o_dat), 32'h00);
    chk("midreset_o_valid", 32'(o_valid), 32'd0);
    chk("midreset_o_err", 32'(o_err), 32'd0);
    chk("midreset_o_busy", 32'(o_busy), 32'd0);
    i_sclr_n = 1'b1;
    realign();
    sb.push_back('{1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1, -1);

    // Edge lands on the terminal-count cycle (64 clk gap): bit accepted.
    sb.push_back('{1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b1, 4);

    for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
